// File: rtl/spi_controller_if.sv
// Request handshake and SPI pin bundle for spi_controller.
// The controller uses the master modport; the request source and any pin
// observer use the slave modport.
interface spi_controller_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       abort;
    logic       busy;
    logic       done;
    logic       nCS;
    logic       SCLK;
    logic       COPI;

    modport master (
        input  req_valid, req_write, req_addr, req_data, abort,
        output req_ready, busy, done, nCS, SCLK, COPI
    );

    modport slave (
        output req_valid, req_write, req_addr, req_data, abort,
        input  req_ready, busy, done, nCS, SCLK, COPI
    );
endinterface

// File: rtl/spi_controller.sv
// SPI mode-0 bus initiator: serialises {write, addr[6:0], data[7:0]} MSB first
// onto nCS/SCLK/COPI. Every output is a flop whose next value is computed one
// cycle ahead in the combinational block.
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.master bus
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] DIV_DONE = 8'(CLK_DIV - 2);
    localparam logic [4:0] NUM_BITS = 5'd16;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] shift_q, shift_d;
    logic        aborted_q, aborted_d;
    logic        ncs_q, ncs_d;
    logic        sclk_q, sclk_d;
    logic        copi_q, copi_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        div_end;

    assign div_end = (div_q == DIV_LAST);

    // Next state and next registered outputs; abort in SETUP/SHIFT overrides the normal sequence.
    always_comb begin
        // NOTE: every _d signal gets a default first so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        aborted_d = aborted_q;
        ncs_d     = ncs_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if ((state_q == SETUP || state_q == SHIFT) && bus.abort) begin
            state_d   = GAP;
            div_d     = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            aborted_d = 1'b1;
            ncs_d     = 1'b1;
            sclk_d    = 1'b0;
            copi_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ready_q && bus.req_valid) begin
                        state_d   = SETUP;
                        div_d     = '0;
                        bit_cnt_d = '0;
                        shift_d   = {bus.req_write, bus.req_addr, bus.req_data};
                        aborted_d = 1'b0;
                        ncs_d     = 1'b0;
                        sclk_d    = 1'b0;
                        copi_d    = bus.req_write;
                        ready_d   = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        state_d   = SHIFT;
                        div_d     = '0;
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_d = div_q + 8'd1;
                    end else begin
                        div_d = '0;
                        if (sclk_q) begin
                            // Falling SCLK: present the next bit for the following rising edge.
                            sclk_d  = 1'b0;
                            shift_d = shift_q << 1;
                            copi_d  = shift_d[15];
                        end else if (bit_cnt_q == NUM_BITS) begin
                            // The 16th low phase doubles as nCS hold time.
                            state_d   = GAP;
                            bit_cnt_d = '0;
                            ncs_d     = 1'b1;
                            copi_d    = 1'b0;
                        end else begin
                            sclk_d    = 1'b1;
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (div_q == DIV_DONE && !aborted_q) begin
                        done_d = 1'b1;
                    end
                    if (div_end) begin
                        state_d = IDLE;
                        div_d   = '0;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            aborted_q <= 1'b0;
            ncs_q     <= 1'b1;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            aborted_q <= aborted_d;
            ncs_q     <= ncs_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.nCS       = ncs_q;
    assign bus.SCLK      = sclk_q;
    assign bus.COPI      = copi_q;

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (bus initiator) that serialises 16-bit register-write frames onto nCS/SCLK/COPI for the design's SPI register peripheral. Frame format is MSB first: write bit, then 7-bit address, then 8-bit data. It runs in SPI mode 0: SCLK idles low, COPI is stable across each SCLK rising edge, and nCS is low for the whole frame. It sits between an on-chip request source (sequencer or test logic) and the SPI pins, using a valid/ready request handshake.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per SCLK half-period. Legal range is 2..255. With the same-clock peripheral, which uses a 2-flop synchroniser, values of 4 or more are required.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  value sent as frame bit 15.
- req_addr  in  7  frame bits 14:8.
- req_data  in  8  frame bits 7:0.
- abort  in  1  terminate the current frame early.
- busy  out  1  a frame is in progress (any state other than IDLE).
- done  out  1  one-cycle pulse when a full 16-bit frame completes.
- nCS  out  1  chip select, active low.
- SCLK  out  1  serial clock.
- COPI  out  1  serial data out.

## Operation
- All outputs are registered.
- Reset values: nCS=1, SCLK=0, COPI=0, req_ready=1, busy=0, done=0. State is IDLE, shift register is 0, counters are 0.
- States are IDLE, SETUP, SHIFT and GAP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid && req_ready) loads shift_reg={req_write, req_addr, req_data} and moves to SETUP.
  - Request inputs are sampled only in the handshake cycle.
- SETUP:
  - Lasts CLK_DIV cycles with nCS=0, SCLK=0 and COPI=shift_reg[15].
  - Then moves to SHIFT.
- SHIFT:
  - Runs 16 bit periods. Each bit period is an SCLK-high phase of CLK_DIV cycles followed by an SCLK-low phase of CLK_DIV cycles.
  - At each high-to-low transition the shift register shifts left and COPI takes the next bit.
  - A 5-bit counter counts the high phases.
  - After the 16th low phase, which acts as the nCS hold time, the state moves to GAP.
- GAP:
  - Lasts CLK_DIV cycles with nCS=1, SCLK=0 and COPI=0. This gives the peripheral time to see the nCS rising edge and commit the frame.
  - done=1 in the last GAP cycle only if the frame was not aborted.
  - Then moves to IDLE.
- abort:
  - In SETUP or SHIFT: the next cycle has nCS=1, SCLK=0, COPI=0 and the state is GAP. The GAP length is a full CLK_DIV cycles and no done is produced. The peripheral discards the partial frame.
  - In IDLE or GAP: ignored. If abort and a handshake coincide in IDLE, the handshake is accepted and abort has no effect.
- req_valid while busy: not accepted, since req_ready=0. No queuing; the request source must hold valid until ready.
- rst asserted in any state: the next cycle shows the reset values. No done is produced and the frame is lost.
- A read frame (req_write=0) is transmitted identically. The peripheral ignores it.

## Timing
Let D=CLK_DIV. Cycle 0 is the handshake cycle; cycle k denotes the registered output value in cycle k.
- Cycles 1..D: SETUP. nCS=0 and SCLK=0.
- Bit i (i=0..15, frame bit 15-i):
  - SCLK=1 in cycles D+1+2iD .. 2D+2iD.
  - SCLK=0 in cycles 2D+1+2iD .. 3D+2iD.
  - COPI=frame[15-i] from cycle 2D+1+2(i-1)D (cycle 1 for i=0) through the end of that high phase.
- nCS=0 in cycles 1..33D. nCS=1 from cycle 33D+1.
- GAP spans cycles 33D+1..34D. done=1 in cycle 34D.
- req_ready=1 again in cycle 34D+1. A new handshake is possible in that same cycle.
- Frame period with back-to-back requests is 34D+1 cycles. For D=4 this is 137 cycles, with nCS high for exactly 5 cycles between frames (4 GAP cycles plus the handshake cycle).
- busy=1 in cycles 1..34D.

## Test plan
- Reset: hold rst high for 3 cycles mid-frame, then release. Required on the next cycle and after release: nCS=1, SCLK=0, COPI=0, req_ready=1, busy=0, done=0.
- Single write, D=4, write=1, addr=0x00, data=0xA5:
  - A sampler on SCLK rising edges captures 0x80A5 with exactly 16 edges.
  - done is high in cycle 136 and req_ready is high in cycle 137.
  - A paired peripheral shows uo_out=0xA5.
- Back-to-back: hold req_valid high with {1,0x01,0x3C} then {1,0x04,0x0F}.
  - The second request is accepted at cycle 137.
  - nCS is high for exactly 5 cycles between frames.
  - The peripheral shows uio_out=0x3C and uo_out=0x0F.
- Busy rejection: pulse req_valid with {1,0x01,0xFF} at cycle 50 of a frame. Required: no handshake, no extra SCLK edges, and uio_out unchanged.
- Abort: assert abort one cycle after the 8th SCLK rising edge.
  - The next cycle has nCS=1 and SCLK=0.
  - No done pulse.
  - req_ready returns D+1 cycles after the abort.
  - Peripheral outputs are unchanged.
- Read frame: write=0, addr=0x00, data=0x55. Required: captured 0x0055, done pulses, peripheral unchanged.
